// File: rtl/piso_sreg_pkg.sv
// Shared framing constants for the 4-bit parallel-in / serial-out register.
package piso_sreg_pkg;
   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
endpackage

// File: rtl/piso_sreg_if.sv
// Parallel data in / serial data out bundle between the source and the serializer.
interface piso_sreg_if;
   logic p3;
   logic p2;
   logic p1;
   logic p0;
   logic sout;

   modport master (output p3, p2, p1, p0, input sout);
   modport slave  (input p3, p2, p1, p0, output sout);
endinterface

// File: rtl/piso_frame_ctr.sv
// Free-running frame counter; o_load marks the edge that captures a new word.
module piso_frame_ctr
   import piso_sreg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic o_load
);
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (r_cnt == CNT_LAST) w_cnt_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_cnt <= '0;
      else      r_cnt <= w_cnt_nxt;
   end

   assign o_load = (r_cnt == '0);
endmodule

// File: rtl/piso_sreg.sv
// 4-bit PISO: loads {p3,p2,p1,p0} every fourth edge and shifts it out on a registered sout.
module piso_sreg
   import piso_sreg_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   piso_sreg_if.slave  bus
);
   logic [FRAME_LEN-1:0] r_sr;
   logic                 w_load;

   piso_frame_ctr u_ctr (
      .clk    (clk),
      .rst    (rst),
      .o_load (w_load)
   );

   // Vacated positions fill with 0 so a frame never carries stale data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           r_sr <= '0;
      else if (w_load)    r_sr <= {bus.p3, bus.p2, bus.p1, bus.p0};
      else if (MSB_FIRST) r_sr <= {r_sr[FRAME_LEN-2:0], 1'b0};
      else                r_sr <= {1'b0, r_sr[FRAME_LEN-1:1]};
   end

   assign bus.sout = MSB_FIRST ? r_sr[FRAME_LEN-1] : r_sr[0];
endmodule

// File: tb/tb_piso_sreg.sv
// Directed bench for piso_sreg: MSB-first and LSB-first instances side by side.
module tb_piso_sreg;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   piso_sreg_if bus_m ();
   piso_sreg_if bus_l ();

   piso_sreg #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
   piso_sreg #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] p;
      logic [7:0] exp_m;   // MSB-first stream, first bit in [7]
      logic [7:0] exp_l;   // LSB-first stream, first bit in [7]
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic setp(input logic [3:0] v);
      {bus_m.p3, bus_m.p2, bus_m.p1, bus_m.p0} = v;
      {bus_l.p3, bus_l.p2, bus_l.p1, bus_l.p0} = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_release(input logic [3:0] v);
      @(negedge clk);
      rst = 1'b0;
      setp(v);
      #1;
      chk("rst_sout_m", {1'b0, bus_m.sout}, 2'b00);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic [7:0] seq;

   initial begin
      tbl[0] = '{p: 4'b1101, exp_m: 8'b1101_1101, exp_l: 8'b1011_1011};
      tbl[1] = '{p: 4'b0000, exp_m: 8'b0000_0000, exp_l: 8'b0000_0000};
      tbl[2] = '{p: 4'b1111, exp_m: 8'b1111_1111, exp_l: 8'b1111_1111};
      tbl[3] = '{p: 4'b1000, exp_m: 8'b1000_1000, exp_l: 8'b0001_0001};
      tbl[4] = '{p: 4'b0110, exp_m: 8'b0110_0110, exp_l: 8'b0110_0110};

      // Reset hold with clock running
      setp(4'b1101);
      #1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_sout_m", {1'b0, bus_m.sout}, 2'b00);
         chk("hold_sout_l", {1'b0, bus_l.sout}, 2'b00);
         chk("hold_cnt", dut_m.u_ctr.r_cnt, 2'd0);
      end

      // Table-driven frames: two back-to-back frames per vector
      for (int v = 0; v < 5; v++) begin
         reset_release(tbl[v].p);
         for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("v%0d_m_bit%0d", v, i), {1'b0, bus_m.sout}, {1'b0, tbl[v].exp_m[7-i]});
            chk($sformatf("v%0d_l_bit%0d", v, i), {1'b0, bus_l.sout}, {1'b0, tbl[v].exp_l[7-i]});
            chk($sformatf("v%0d_cnt%0d", v, i), dut_m.u_ctr.r_cnt, 2'((i + 1) % 4));
         end
      end

      // Mid-frame input change is ignored until the next load
      reset_release(4'b1101);
      tick();
      tick();
      @(negedge clk);
      setp(4'b0010);
      seq = 8'b0100_1000;   // 0,1 then 0,0,1,0 then first bit of 0010 again
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("mid_m_bit%0d", i), {1'b0, bus_m.sout}, {1'b0, seq[7-i]});
      end

      // Async reset between edges during the third bit
      reset_release(4'b1111);
      tick();
      tick();
      tick();
      chk("pre_arst_sout", {1'b0, bus_m.sout}, 2'b01);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_sout_m", {1'b0, bus_m.sout}, 2'b00);
      chk("arst_sout_l", {1'b0, bus_l.sout}, 2'b00);
      chk("arst_cnt", dut_m.u_ctr.r_cnt, 2'd0);
      setp(4'b1000);
      @(negedge clk);
      rst = 1'b1;
      seq = 8'b1000_1000;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("post_arst_m_bit%0d", i), {1'b0, bus_m.sout}, {1'b0, seq[7-i]});
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/piso_sreg.md
Name: piso_sreg

Overview:
- 4-bit parallel-in, serial-out shift register.
- Captures a 4-bit word presented on four single-bit inputs, then emits it one bit per clock, MSB first, on a single serial output.
- Framing is free-running and self-timed by an internal 2-bit frame counter, so no load/enable pins are needed.
- Sits at a parallel-to-serial boundary, e.g. feeding a 1-wire serial link or a test output pin.

Parameters:
- MSB_FIRST, 1, 1: serialize p3,p2,p1,p0; 0: serialize p0,p1,p2,p3.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- p3  input  1  parallel data bit 3 (MSB)
- p2  input  1  parallel data bit 2
- p1  input  1  parallel data bit 1
- p0  input  1  parallel data bit 0 (LSB)
- sout  output  1  serial data out, registered

Behaviour:
- State: 4-bit shift register sr[3:0]; 2-bit frame counter cnt[1:0].
- sout is driven by sr[3] (MSB_FIRST=1) or sr[0] (MSB_FIRST=0). There is no combinational path from p* to sout.
- Reset:
  - rst low immediately clears sr to 0000 and cnt to 0, regardless of clk; sout = 0.
  - Held while rst = 0.
- Load edge: the first rising clk edge after rst goes high has cnt==0:
  - sr <= {p3,p2,p1,p0}; cnt <= 1.
  - sout shows the first serial bit (p3 for MSB_FIRST=1) after that edge.
- Shift edges: on edges with cnt = 1, 2, 3:
  - MSB_FIRST=1: sr <= {sr[2:0],1'b0}.
  - MSB_FIRST=0: sr <= {1'b0,sr[3:1]}.
  - cnt <= cnt+1, wrapping 3 -> 0.
- Frame: exactly 4 clocks.
  - Bits appear in order p3,p2,p1,p0 on sout over 4 consecutive cycles.
  - The next edge (cnt==0) reloads from the current p inputs. Streaming is continuous, with no idle gap between frames.
- Latency: one clock from the load edge to the first bit on sout.
- Parallel inputs are sampled only on load edges; changes mid-frame have no effect until the next load.
- Reset mid-frame: the frame is aborted and sout drops to 0 asynchronously. On release, a fresh frame starts at the next edge with a load.
- Reset deasserted coincident with a clk edge: that edge is not counted; loading occurs on the following edge.
- No X propagation: all state is reset, and sout is never X after reset.

Decomposition:
- Shared package: localparam FRAME_LEN = 4 and counter width CNT_W = 2.
- One natural sub-module: piso_frame_ctr. It owns the 2-bit wrap counter and a load strobe (cnt==0).
- The top holds sr and the output mux.

Test Plan:
- Reset hold: rst=0, p=1101, clk running 5 cycles -> sout=0 throughout, no X.
- Basic frame: p=1101, release rst -> sout over next 8 edges = 1,1,0,1,1,1,0,1 (continuous repeat).
- Mid-frame input change: p=1101 loaded, change p to 0010 after 2nd bit -> current frame finishes 0,1; next frame 0,0,1,0.
- Async reset mid-frame: pull rst low between edges during 3rd bit -> sout=0 immediately without clock edge. Release with p=1000 -> 1,0,0,0.
- Patterns 0000 and 1111 -> constant 0 and constant 1 streams, with a correct 4-cycle period via an internal counter probe.
- MSB_FIRST=0, p=1101 -> sout sequence 1,0,1,1 repeating.
